// File: rtl/cache_axi_responder.sv
// Memory-side responder for the cache refill/writeback port: line and single-word
// reads against a 1-cycle SRAM, with a one-entry write buffer drained in port gaps.
module cache_axi_responder #(
   parameter logic [2:0] LINE_TYPE = 3'b100
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rd_req,
   input  logic [2:0]   rd_type,
   input  logic [31:0]  rd_addr,
   output logic         rd_rdy,
   output logic         ret_valid,
   output logic [1:0]   ret_last,
   output logic [31:0]  ret_data,
   input  logic         wr_req,
   input  logic [2:0]   wr_type,
   input  logic [31:0]  wr_addr,
   input  logic [3:0]   wr_wstrb,
   input  logic [127:0] wr_data,
   output logic         wr_rdy,
   output logic         mem_en,
   output logic [3:0]   mem_we,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   input  logic [31:0]  mem_rdata
);

   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_LAST} rd_state_e;

   rd_state_e      rd_state_q, rd_state_d;
   logic [31:2]    rd_base_q, rd_base_d;
   logic           rd_line_q, rd_line_d;
   logic [1:0]     rd_beat_q, rd_beat_d;
   logic           ret_pend_q, ret_pend_d;
   logic           ret_fin_q, ret_fin_d;

   logic           wbuf_valid_q, wbuf_valid_d;
   logic [31:2]    wbuf_addr_q, wbuf_addr_d;
   logic [2:0]     wbuf_type_q, wbuf_type_d;
   logic [3:0]     wbuf_wstrb_q, wbuf_wstrb_d;
   logic [127:0]   wbuf_data_q, wbuf_data_d;
   logic [1:0]     wbuf_beat_q, wbuf_beat_d;

   logic           line_conflict;
   logic           rd_acc;
   logic           wr_acc;
   logic           wbuf_line;
   logic           unused_addr_bits;

   assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0]};
   assign wbuf_line        = (wbuf_type_q == LINE_TYPE);

   // A read of a line that is buffered, or being written this cycle, waits for the drain.
   assign line_conflict = (wbuf_valid_q && (wbuf_addr_q[31:4] == rd_addr[31:4])) ||
                          (wr_req && (wr_addr[31:4] == rd_addr[31:4]));
   assign rd_rdy = !reset && (rd_state_q == R_IDLE) && !line_conflict;
   assign wr_rdy = !reset && !wbuf_valid_q;
   assign rd_acc = rd_req && rd_rdy;
   assign wr_acc = wr_req && wr_rdy;

   assign ret_valid = ret_pend_q && !reset;
   assign ret_last  = {1'b0, ret_fin_q && !reset};
   assign ret_data  = ret_valid ? mem_rdata : 32'h0;

   always_comb begin
      rd_state_d   = rd_state_q;
      rd_base_d    = rd_base_q;
      rd_line_d    = rd_line_q;
      rd_beat_d    = rd_beat_q;
      ret_pend_d   = 1'b0;
      ret_fin_d    = 1'b0;
      wbuf_valid_d = wbuf_valid_q;
      wbuf_addr_d  = wbuf_addr_q;
      wbuf_type_d  = wbuf_type_q;
      wbuf_wstrb_d = wbuf_wstrb_q;
      wbuf_data_d  = wbuf_data_q;
      wbuf_beat_d  = wbuf_beat_q;
      mem_en       = 1'b0;
      mem_we       = 4'h0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;

      case (rd_state_q)
         R_IDLE: begin
            if (rd_acc) begin
               rd_state_d = R_ISSUE;
               rd_line_d  = (rd_type == LINE_TYPE);
               rd_base_d  = (rd_type == LINE_TYPE) ? {rd_addr[31:4], 2'b00} : rd_addr[31:2];
               rd_beat_d  = 2'd0;
            end
         end
         R_ISSUE: begin
            mem_en     = 1'b1;
            mem_addr   = {rd_base_q + 30'(rd_beat_q), 2'b00};
            ret_pend_d = 1'b1;
            rd_beat_d  = rd_beat_q + 2'd1;
            if (!rd_line_q || (rd_beat_q == 2'd3)) begin
               ret_fin_d  = 1'b1;
               rd_state_d = R_LAST;
            end
         end
         R_LAST:  rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase

      // Drain only fills port gaps left by the read FSM; the beat index survives stalls.
      if (wbuf_valid_q && (rd_state_q != R_ISSUE)) begin
         mem_en = 1'b1;
         if (wbuf_line) begin
            mem_we    = 4'hf;
            mem_addr  = {wbuf_addr_q[31:4], wbuf_beat_q, 2'b00};
            mem_wdata = wbuf_data_q[{wbuf_beat_q, 5'b0} +: 32];
         end else begin
            mem_we    = wbuf_wstrb_q;
            mem_addr  = {wbuf_addr_q, 2'b00};
            mem_wdata = wbuf_data_q[31:0];
         end
         wbuf_beat_d = wbuf_beat_q + 2'd1;
         if (!wbuf_line || (wbuf_beat_q == 2'd3)) begin
            wbuf_valid_d = 1'b0;
            wbuf_beat_d  = 2'd0;
         end
      end

      if (wr_acc) begin
         wbuf_valid_d = 1'b1;
         wbuf_addr_d  = wr_addr[31:2];
         wbuf_type_d  = wr_type;
         wbuf_wstrb_d = wr_wstrb;
         wbuf_data_d  = wr_data;
         wbuf_beat_d  = 2'd0;
      end

      if (reset) begin
         mem_en = 1'b0;
         mem_we = 4'h0;
      end
   end

   // NOTE: only control state is reset; buffer payload is qualified by wbuf_valid_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state_q   <= R_IDLE;
         rd_beat_q    <= 2'd0;
         ret_pend_q   <= 1'b0;
         ret_fin_q    <= 1'b0;
         wbuf_valid_q <= 1'b0;
         wbuf_beat_q  <= 2'd0;
      end else begin
         rd_state_q   <= rd_state_d;
         rd_beat_q    <= rd_beat_d;
         ret_pend_q   <= ret_pend_d;
         ret_fin_q    <= ret_fin_d;
         wbuf_valid_q <= wbuf_valid_d;
         wbuf_beat_q  <= wbuf_beat_d;
      end
   end

   always_ff @(posedge clk) begin
      rd_base_q    <= rd_base_d;
      rd_line_q    <= rd_line_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_type_q  <= wbuf_type_d;
      wbuf_wstrb_q <= wbuf_wstrb_d;
      wbuf_data_q  <= wbuf_data_d;
   end

endmodule

// File: tb/tb_cache_axi_responder.sv
// Scoreboard bench for cache_axi_responder: SRAM model behind the DUT, reference
// memory updated at write acceptance, expected issues/beats/drains queued and popped.
module tb_cache_axi_responder;

   localparam logic [2:0] LINE_TYPE = 3'b100;
   localparam logic [2:0] WORD_TYPE = 3'b010;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic [1:0]   ret_last;
   logic [31:0]  ret_data;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;
   logic         mem_en;
   logic [3:0]   mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;

   always #5 clk = ~clk;

   cache_axi_responder #(.LINE_TYPE(LINE_TYPE)) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
      .wr_data(wr_data), .wr_rdy(wr_rdy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   logic [31:0] sram    [0:1023];
   logic [31:0] ref_mem [0:1023];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 4'h0) mem_rdata <= sram[mem_addr[11:2]];
         else
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) sram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   typedef struct { logic [31:0] data; logic [1:0] last; int cyc; } ret_t;
   typedef struct { logic [31:0] addr; int cyc; } iss_t;
   typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] data; int k; } wr_t;

   ret_t ret_q[$];
   iss_t iss_q[$];
   wr_t  wr_q[$];
   ret_t re;
   iss_t ie;
   wr_t  we_e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_acc_cyc = 0;
   int wr_acc_cyc = 0;
   int drain_start_cyc = 0;
   int drain_end_cyc = 0;
   int ret_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: compares DUT activity against queued expectations, then queues new ones.
   always @(negedge clk) begin
      if (reset) begin
         ret_q.delete();
         iss_q.delete();
         wr_q.delete();
         check("rst_ret_valid", ret_valid, 0);
         check("rst_outputs", {ret_last, ret_data, mem_en, mem_we, rd_rdy, wr_rdy}, 0);
      end else begin
         if (mem_en && mem_we == 4'h0) begin
            if (iss_q.size() == 0) check("rd_issue_unexpected", mem_addr, 0);
            else begin
               ie = iss_q.pop_front();
               check("rd_issue_addr", mem_addr, ie.addr);
               check("rd_issue_cyc", cyc, ie.cyc);
            end
         end
         if (mem_en && mem_we != 4'h0) begin
            if (wr_q.size() == 0) check("drain_unexpected", mem_addr, 0);
            else begin
               we_e = wr_q.pop_front();
               check("drain_addr", mem_addr, we_e.addr);
               check("drain_we", mem_we, we_e.we);
               check("drain_wdata", mem_wdata, we_e.data);
               if (we_e.k == 0) drain_start_cyc = cyc;
               drain_end_cyc = cyc;
            end
         end
         if (ret_valid) begin
            ret_seen++;
            if (ret_q.size() == 0) check("ret_unexpected", ret_data, 0);
            else begin
               re = ret_q.pop_front();
               check("ret_data", ret_data, re.data);
               check("ret_last", ret_last, re.last);
               check("ret_cyc", cyc, re.cyc);
            end
         end
         if (rd_req && rd_rdy) begin
            int n;
            logic [31:0] base, a;
            rd_acc_cyc = cyc;
            n    = (rd_type == LINE_TYPE) ? 4 : 1;
            base = (n == 4) ? {rd_addr[31:4], 4'h0} : {rd_addr[31:2], 2'b00};
            for (int k = 0; k < n; k++) begin
               a = base + 32'(4 * k);
               iss_q.push_back('{a, cyc + 1 + k});
               ret_q.push_back('{ref_mem[a[11:2]], (k == n - 1) ? 2'b01 : 2'b00, cyc + 2 + k});
            end
         end
         if (wr_req && wr_rdy) begin
            logic [31:0] a;
            wr_acc_cyc = cyc;
            if (wr_type == LINE_TYPE) begin
               for (int k = 0; k < 4; k++) begin
                  a = {wr_addr[31:4], 4'h0} + 32'(4 * k);
                  wr_q.push_back('{a, 4'hf, wr_data[32*k +: 32], k});
                  ref_mem[a[11:2]] = wr_data[32*k +: 32];
               end
            end else begin
               a = {wr_addr[31:2], 2'b00};
               wr_q.push_back('{a, wr_wstrb, wr_data[31:0], 0});
               for (int b = 0; b < 4; b++)
                  if (wr_wstrb[b]) ref_mem[a[11:2]][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
   end

   task automatic req(input logic do_rd, input logic [2:0] rt, input logic [31:0] ra,
                      input logic do_wr, input logic [2:0] wt, input logic [31:0] wa,
                      input logic [3:0] ws, input logic [127:0] wd);
      logic rd_done, wr_done;
      int n;
      rd_req = do_rd; rd_type = rt; rd_addr = ra;
      wr_req = do_wr; wr_type = wt; wr_addr = wa; wr_wstrb = ws; wr_data = wd;
      rd_done = !do_rd;
      wr_done = !do_wr;
      n = 0;
      while (!(rd_done && wr_done) && n < 300) begin
         @(negedge clk);
         if (rd_req && rd_rdy) rd_done = 1'b1;
         if (wr_req && wr_rdy) wr_done = 1'b1;
         @(posedge clk);
         #1;
         if (rd_done) rd_req = 1'b0;
         if (wr_done) wr_req = 1'b0;
         n++;
      end
      if (!(rd_done && wr_done)) check("req_accept_timeout", {rd_done, wr_done}, 2'b11);
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      logic idle;
      n = 0;
      idle = 1'b0;
      while (!idle && n < 300) begin
         @(negedge clk);
         idle = (ret_q.size() == 0) && (iss_q.size() == 0) && (wr_q.size() == 0) && wr_rdy;
         n++;
      end
      if (!idle) check("idle_timeout", idle, 1);
      @(posedge clk);
      #1;
   endtask

   logic [31:0]  saved [0:3];
   logic [127:0] line_d;
   int           base_seen;
   int           n;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         sram[i]    = 32'hC000_0000 | i;
         ref_mem[i] = 32'hC000_0000 | i;
      end
      for (int i = 0; i < 4; i++) begin
         sram[32'h40 + i]    = 32'hA0 + i;
         ref_mem[32'h40 + i] = 32'hA0 + i;
      end
      sram[32'h81]    = 32'h55;
      ref_mem[32'h81] = 32'h55;

      reset = 1'b1;
      rd_req = 1'b0; rd_type = 3'b0; rd_addr = 32'h0;
      wr_req = 1'b0; wr_type = 3'b0; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = 128'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Line read @0x108: wraps to line base, rd_rdy returns at T+6.
      req(1, LINE_TYPE, 32'h108, 0, 3'b0, 32'h0, 4'h0, 128'h0);
      n = 0;
      while (cyc < rd_acc_cyc + 6 && n < 20) begin
         @(negedge clk);
         if (cyc < rd_acc_cyc + 6) check("t1_rd_rdy_busy", rd_rdy, 0);
         else                      check("t1_rd_rdy_back", rd_rdy, 1);
         n++;
      end
      wait_idle();

      // Single word read @0x204.
      req(1, WORD_TYPE, 32'h204, 0, 3'b0, 32'h0, 4'h0, 128'h0);
      wait_idle();

      // Line write @0x300, then read back.
      line_d = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
      req(0, 3'b0, 32'h0, 1, LINE_TYPE, 32'h300, 4'h0, line_d);
      @(negedge clk);
      check("t3_wr_rdy_busy", wr_rdy, 0);
      wait_idle();
      check("t3_drain_start", drain_start_cyc, wr_acc_cyc + 1);
      check("t3_wr_rdy_after", wr_rdy, 1);
      req(1, LINE_TYPE, 32'h30C, 0, 3'b0, 32'h0, 4'h0, 128'h0);
      wait_idle();

      // Same-line write and read: read waits for the drain to finish.
      line_d = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
      req(1, LINE_TYPE, 32'h400, 1, LINE_TYPE, 32'h400, 4'h0, line_d);
      wait_idle();
      check("t4_read_after_drain", rd_acc_cyc, drain_end_cyc + 1);

      // Different lines: both accepted together, drain starts after the read issues.
      line_d = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
      req(1, LINE_TYPE, 32'h600, 1, LINE_TYPE, 32'h500, 4'h0, line_d);
      check("t5_same_cycle", wr_acc_cyc, rd_acc_cyc);
      wait_idle();
      check("t5_drain_start", drain_start_cyc, rd_acc_cyc + 5);

      // Reset at the 2nd return beat abandons the burst and the buffered write.
      for (int i = 0; i < 4; i++) saved[i] = ref_mem[32'h1C0 + i];
      line_d = {32'hBAD3, 32'hBAD2, 32'hBAD1, 32'hBAD0};
      req(1, LINE_TYPE, 32'h100, 1, LINE_TYPE, 32'h700, 4'h0, line_d);
      base_seen = ret_seen;
      n = 0;
      while (ret_seen < base_seen + 2 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("t6_two_beats", ret_seen, base_seen + 2);
      reset = 1'b1;
      @(negedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[32'h1C0 + i] = saved[i];
      repeat (5) begin
         @(negedge clk);
         check("t6_no_beats", ret_valid, 0);
      end
      check("t6_rdys", {rd_rdy, wr_rdy}, 2'b11);
      req(1, LINE_TYPE, 32'h700, 0, 3'b0, 32'h0, 4'h0, 128'h0);
      wait_idle();

      // Random mix, including unsupported types treated as single word.
      for (int it = 0; it < 40; it++) begin
         logic dr, dw;
         dr = 1'($urandom_range(0, 1));
         dw = 1'($urandom_range(0, 1));
         if (!dr && !dw) dr = 1'b1;
         req(dr, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 32'h6FC)),
             dw, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 32'h6FC)),
             4'($urandom_range(1, 15)),
             {$urandom, $urandom, $urandom, $urandom});
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_idle();
      for (int a = 32'h000; a < 32'h700; a += 16)
         req(1, LINE_TYPE, 32'(a), 0, 3'b0, 32'h0, 4'h0, 128'h0);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "bench timeout");
   end

endmodule
